// File: rtl/sdram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_pkg : shared SDRAM command encodings, scheduler state type and helpers
// Revision  : 1.0
// ---------------------------------------------------------------------------
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0]  CMD_NOP          = 4'b0111;
  localparam logic [3:0]  CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0]  CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0]  CMD_LOAD_MODE    = 4'b0000;

  localparam logic [1:0]  BA_ALL   = 2'b11;
  localparam logic [11:0] ADDR_ALL = 12'hfff;

  typedef enum logic [3:0] {
    S_POWERUP   = 4'd0,
    S_PRE       = 4'd1,
    S_WAIT_TRP  = 4'd2,
    S_AREF      = 4'd3,
    S_WAIT_TRFC = 4'd4,
    S_MRS       = 4'd5,
    S_WAIT_MRS  = 4'd6,
    S_IDLE      = 4'd7,
    S_USER      = 4'd8
  } sched_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_delay_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_delay_timer : up-counter that pulses o_expire on the i_load-th enabled
//                     cycle after i_start (or reset), then wraps to zero.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module sdram_delay_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_load,
  output logic             o_expire
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] w_last;

  always_comb begin
    w_last   = i_load - WIDTH'(1);
    o_expire = i_en && (cnt_q == w_last);
    cnt_d    = cnt_q;
    if (i_start || o_expire) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_init_refresh_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_init_refresh_scheduler : SDRAM power-up init, periodic auto-refresh and
//                                bus arbitration between refresh and one user.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module sdram_init_refresh_scheduler
  import sdram_pkg::*;
#(
  parameter int T_POWERUP_CYC = 10000,
  parameter int T_REFI_CYC    = 780,
  parameter int TRP_CYC       = 2,
  parameter int TRFC_CYC      = 7,
  parameter int INIT_REF_NUM  = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic        sdram_init,
  output logic        mode_reg_en,
  input  logic        mode_reg_done,
  input  logic [3:0]  ld_cmd,
  input  logic [1:0]  ld_ba,
  input  logic [11:0] ld_addr,
  input  logic        user_req,
  output logic        user_gnt,
  input  logic        user_done,
  input  logic [3:0]  user_cmd,
  input  logic [1:0]  user_ba,
  input  logic [11:0] user_addr,
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic        init_done,
  output logic        ref_miss
);

  localparam int WAIT_W = $clog2(max3(T_POWERUP_CYC, TRP_CYC, TRFC_CYC) + 1);
  localparam int REFI_W = $clog2(T_REFI_CYC + 1);
  localparam int AREF_W = $clog2(INIT_REF_NUM + 1);

  sched_state_t      state_q, state_d;
  logic [3:0]        own_cmd_q, own_cmd_d;
  logic [AREF_W-1:0] aref_cnt_q, aref_cnt_d;
  logic              cke_q;
  logic              init_done_q, init_done_d;
  logic              sdram_init_q, sdram_init_d;
  logic              mode_reg_en_q, mode_reg_en_d;
  logic              user_gnt_q, user_gnt_d;
  logic              ref_pending_q, ref_pending_d;
  logic              ref_miss_q, ref_miss_d;

  logic [WAIT_W-1:0] wait_load;
  logic              wait_en, wait_start, wait_expire;
  logic              refi_tick, mrs_ack, ref_clear;

  sdram_delay_timer #(.WIDTH(WAIT_W)) u_wait_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .i_en     (wait_en),
    .i_start  (wait_start),
    .i_load   (wait_load),
    .o_expire (wait_expire)
  );

  sdram_delay_timer #(.WIDTH(REFI_W)) u_refi_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .i_en     (init_done_q),
    .i_start  (mrs_ack),
    .i_load   (REFI_W'(T_REFI_CYC)),
    .o_expire (refi_tick)
  );

  always_comb begin
    mrs_ack    = (state_q == S_WAIT_MRS) && mode_reg_done;
    ref_clear  = (state_q == S_AREF) && init_done_q;
    wait_en    = (state_q == S_POWERUP) || (state_q == S_WAIT_TRP) || (state_q == S_WAIT_TRFC);
    wait_start = (state_q == S_PRE) || (state_q == S_AREF);
    case (state_q)
      S_POWERUP:  wait_load = WAIT_W'(T_POWERUP_CYC);
      S_WAIT_TRP: wait_load = WAIT_W'(TRP_CYC);
      default:    wait_load = WAIT_W'(TRFC_CYC);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    aref_cnt_d  = aref_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      S_POWERUP:   if (wait_expire) state_d = S_PRE;
      S_PRE:       state_d = S_WAIT_TRP;
      S_WAIT_TRP:  if (wait_expire) state_d = S_AREF;
      S_AREF: begin
        state_d = S_WAIT_TRFC;
        if (!init_done_q) aref_cnt_d = aref_cnt_q + AREF_W'(1);
      end
      S_WAIT_TRFC: begin
        if (wait_expire) begin
          if (init_done_q)                              state_d = S_IDLE;
          else if (aref_cnt_q == AREF_W'(INIT_REF_NUM)) state_d = S_MRS;
          else                                          state_d = S_AREF;
        end
      end
      S_MRS:       state_d = S_WAIT_MRS;
      S_WAIT_MRS: begin
        if (mode_reg_done) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      // A refresh expiring this very cycle beats a user request sampled now.
      S_IDLE: begin
        if (ref_pending_q || refi_tick) state_d = S_PRE;
        else if (user_req)              state_d = S_USER;
      end
      S_USER:      if (user_done) state_d = S_IDLE;
      default:     state_d = S_POWERUP;
    endcase

    ref_pending_d = ref_pending_q;
    ref_miss_d    = ref_miss_q;
    if (refi_tick) begin
      ref_pending_d = 1'b1;
      if (ref_pending_q && !ref_clear) ref_miss_d = 1'b1;
    end else if (ref_clear) begin
      ref_pending_d = 1'b0;
    end

    sdram_init_d  = (state_d == S_MRS) || (state_d == S_WAIT_MRS);
    mode_reg_en_d = (state_d == S_MRS);
    user_gnt_d    = (state_d == S_USER);
    case (state_d)
      S_PRE:   own_cmd_d = CMD_PRECHARGE;
      S_AREF:  own_cmd_d = CMD_AUTO_REFRESH;
      default: own_cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= S_POWERUP;
      own_cmd_q     <= CMD_NOP;
      aref_cnt_q    <= '0;
      cke_q         <= 1'b0;
      init_done_q   <= 1'b0;
      sdram_init_q  <= 1'b0;
      mode_reg_en_q <= 1'b0;
      user_gnt_q    <= 1'b0;
      ref_pending_q <= 1'b0;
      ref_miss_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      own_cmd_q     <= own_cmd_d;
      aref_cnt_q    <= aref_cnt_d;
      cke_q         <= 1'b1;
      init_done_q   <= init_done_d;
      sdram_init_q  <= sdram_init_d;
      mode_reg_en_q <= mode_reg_en_d;
      user_gnt_q    <= user_gnt_d;
      ref_pending_q <= ref_pending_d;
      ref_miss_q    <= ref_miss_d;
    end
  end

  always_comb begin
    case (state_q)
      S_MRS, S_WAIT_MRS: begin
        sdram_cmd  = ld_cmd;
        sdram_ba   = ld_ba;
        sdram_addr = ld_addr;
      end
      S_USER: begin
        sdram_cmd  = user_cmd;
        sdram_ba   = user_ba;
        sdram_addr = user_addr;
      end
      default: begin
        sdram_cmd  = own_cmd_q;
        sdram_ba   = BA_ALL;
        sdram_addr = ADDR_ALL;
      end
    endcase
  end

  assign sdram_cke   = cke_q;
  assign init_done   = init_done_q;
  assign sdram_init  = sdram_init_q;
  assign mode_reg_en = mode_reg_en_q;
  assign user_gnt    = user_gnt_q;
  assign ref_miss    = ref_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_refresh_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sdram_init_refresh_scheduler : cycle-exact self-checking bench for the
//                                   SDRAM init / refresh / user scheduler.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module tb_sdram_init_refresh_scheduler;

  localparam logic [3:0]  NOP  = 4'b0111;
  localparam logic [3:0]  PRE  = 4'b0010;
  localparam logic [3:0]  AREF = 4'b0001;
  localparam logic [3:0]  LD_CMD  = 4'b0000;
  localparam logic [1:0]  LD_BA   = 2'b01;
  localparam logic [11:0] LD_ADDR = 12'h032;

  logic        sys_clk, sys_rst;
  logic        sdram_init, mode_reg_en, mode_reg_done;
  logic [3:0]  ld_cmd;
  logic [1:0]  ld_ba;
  logic [11:0] ld_addr;
  logic        user_req, user_gnt, user_done;
  logic [3:0]  user_cmd;
  logic [1:0]  user_ba;
  logic [11:0] user_addr;
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic        init_done, ref_miss;

  sdram_init_refresh_scheduler #(
    .T_POWERUP_CYC(20), .T_REFI_CYC(60), .TRP_CYC(2), .TRFC_CYC(4), .INIT_REF_NUM(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .sdram_init(sdram_init), .mode_reg_en(mode_reg_en), .mode_reg_done(mode_reg_done),
    .ld_cmd(ld_cmd), .ld_ba(ld_ba), .ld_addr(ld_addr),
    .user_req(user_req), .user_gnt(user_gnt), .user_done(user_done),
    .user_cmd(user_cmd), .user_ba(user_ba), .user_addr(user_addr),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .init_done(init_done), .ref_miss(ref_miss)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Loader model: completion pulse 5 cycles after the start pulse.
  logic [4:0] ld_sr;
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) ld_sr <= '0;
    else         ld_sr <= {ld_sr[3:0], mode_reg_en};
  end
  assign mode_reg_done = ld_sr[4];

  typedef struct {
    logic        req, done;
    logic [3:0]  ucmd;
    logic [1:0]  uba;
    logic [11:0] uaddr;
    logic [3:0]  e_cmd;
    logic [1:0]  e_ba;
    logic [11:0] e_addr;
    logic        e_cke, e_gnt, e_men, e_sinit, e_idone, e_miss;
  } vec_t;

  vec_t  sb_q[$];
  vec_t  tbl[10];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  string phase    = "";

  function automatic vec_t own(input logic [3:0] cmd, input logic req, input logic idone,
                               input logic miss);
    vec_t v;
    v.req = req; v.done = 1'b0; v.ucmd = 4'b0011; v.uba = 2'b10; v.uaddr = 12'h5a5;
    v.e_cmd = cmd; v.e_ba = 2'b11; v.e_addr = 12'hfff;
    v.e_cke = 1'b1; v.e_gnt = 1'b0; v.e_men = 1'b0; v.e_sinit = 1'b0;
    v.e_idone = idone; v.e_miss = miss;
    return v;
  endfunction

  // Granted cycles must show the user's own bus; otherwise the bus idles at NOP.
  function automatic vec_t mk(input logic req, input logic done, input logic [3:0] ucmd,
                              input logic [1:0] uba, input logic [11:0] uaddr,
                              input logic gnt, input logic idone, input logic miss);
    vec_t v;
    v = own(NOP, req, idone, miss);
    v.done = done; v.ucmd = ucmd; v.uba = uba; v.uaddr = uaddr; v.e_gnt = gnt;
    if (gnt) begin
      v.e_cmd = ucmd; v.e_ba = uba; v.e_addr = uaddr;
    end
    return v;
  endfunction

  function automatic vec_t init_exp(input int c);
    vec_t v;
    v = own(NOP, 1'b0, 1'b0, 1'b0);
    if (c == 20) v.e_cmd = PRE;
    else if (c == 23 || c == 28) v.e_cmd = AREF;
    else if (c >= 33 && c <= 38) begin
      v.e_cmd = LD_CMD; v.e_ba = LD_BA; v.e_addr = LD_ADDR;
      v.e_sinit = 1'b1; v.e_men = (c == 33);
    end else if (c >= 39) v.e_idone = 1'b1;
    return v;
  endfunction

  task automatic check_out();
    vec_t e;
    logic [23:0] act, want;
    e    = sb_q.pop_front();
    act  = {sdram_cmd, sdram_ba, sdram_addr, sdram_cke, user_gnt, mode_reg_en,
            sdram_init, init_done, ref_miss};
    want = {e.e_cmd, e.e_ba, e.e_addr, e.e_cke, e.e_gnt, e.e_men,
            e.e_sinit, e.e_idone, e.e_miss};
    n_checks++;
    if (act !== want)
      $display("FAIL %s cyc=%0d got {cmd,ba,addr,cke,gnt,men,init,done,miss}=%h want=%h",
               phase, cyc, act, want);
    else
      n_pass++;
  endtask

  // Drive one cycle of inputs, then compare the outputs of the following cycle.
  task automatic step(input vec_t v);
    user_req = v.req; user_done = v.done;
    user_cmd = v.ucmd; user_ba = v.uba; user_addr = v.uaddr;
    sb_q.push_back(v);
    @(negedge sys_clk);
    cyc++;
    check_out();
  endtask

  task automatic chk_reset(input string nm);
    logic [23:0] act;
    act = {sdram_cmd, sdram_ba, sdram_addr, sdram_cke, user_gnt, mode_reg_en,
           sdram_init, init_done, ref_miss};
    n_checks++;
    if (act !== {4'b0111, 2'b11, 12'hfff, 6'b000000})
      $display("FAIL %s got {cmd,ba,addr,cke,gnt,men,init,done,miss}=%h want=%h",
               nm, act, {4'b0111, 2'b11, 12'hfff, 6'b000000});
    else
      n_pass++;
  endtask

  task automatic reset_pulse(input string nm);
    #2 sys_rst = 1'b1;
    user_req = 1'b0; user_done = 1'b0;
    #1 chk_reset({nm, "_async"});
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1 chk_reset({nm, "_release"});
    cyc = 0;
  endtask

  task automatic run_init(input int upto);
    for (int c = 1; c <= upto; c++) step(init_exp(c));
  endtask

  initial begin
    tbl[0] = mk(1'b1, 1'b0, 4'b0011, 2'b10, 12'h5a5, 1'b0, 1'b1, 1'b0);
    tbl[1] = mk(1'b1, 1'b0, 4'b0011, 2'b10, 12'h5a5, 1'b1, 1'b1, 1'b0);
    tbl[2] = mk(1'b1, 1'b0, 4'b0101, 2'b01, 12'h123, 1'b1, 1'b1, 1'b0);
    tbl[3] = mk(1'b0, 1'b1, 4'b0100, 2'b01, 12'h400, 1'b0, 1'b1, 1'b0);
    tbl[4] = mk(1'b0, 1'b0, 4'b0110, 2'b00, 12'h000, 1'b0, 1'b1, 1'b0);
    tbl[5] = mk(1'b1, 1'b0, 4'b0011, 2'b00, 12'h0a0, 1'b1, 1'b1, 1'b0);
    tbl[6] = mk(1'b1, 1'b1, 4'b1000, 2'b10, 12'h7ff, 1'b0, 1'b1, 1'b0);
    tbl[7] = mk(1'b1, 1'b0, 4'b0100, 2'b10, 12'h7fe, 1'b1, 1'b1, 1'b0);
    tbl[8] = mk(1'b0, 1'b1, 4'b0111, 2'b11, 12'h001, 1'b0, 1'b1, 1'b0);
    tbl[9] = mk(1'b0, 1'b0, 4'b0101, 2'b00, 12'h002, 1'b0, 1'b1, 1'b0);

    ld_cmd = LD_CMD; ld_ba = LD_BA; ld_addr = LD_ADDR;
    user_req = 1'b0; user_done = 1'b0;
    user_cmd = 4'b0011; user_ba = 2'b10; user_addr = 12'h5a5;
    sys_rst = 1'b1;
    @(negedge sys_clk);

    phase = "init";
    reset_pulse("reset");
    run_init(39);

    phase = "idle_refresh";
    for (int c = 40; c <= 166; c++) begin
      if (c == 99 || c == 159)      step(own(PRE, 1'b0, 1'b1, 1'b0));
      else if (c == 102 || c == 162) step(own(AREF, 1'b0, 1'b1, 1'b0));
      else                           step(own(NOP, 1'b0, 1'b1, 1'b0));
    end

    phase = "user_table";
    for (int i = 0; i < 10; i++) step(tbl[i]);

    phase = "ref_vs_req";
    for (int c = 177; c <= 218; c++) step(own(NOP, 1'b0, 1'b1, 1'b0));
    for (int c = 219; c <= 357; c++) begin
      if (c == 219)      step(own(PRE, 1'b1, 1'b1, 1'b0));
      else if (c == 222) step(own(AREF, 1'b1, 1'b1, 1'b0));
      else if (c < 228)  step(own(NOP, 1'b1, 1'b1, 1'b0));
      else begin
        phase = "long_user";
        step(mk(1'b1, 1'b0, 4'(c), 2'(c >> 4), 12'(c * 3), 1'b1, 1'b1, c >= 339));
      end
    end
    step(mk(1'b0, 1'b1, 4'b0100, 2'b00, 12'h010, 1'b0, 1'b1, 1'b1));
    phase = "after_release";
    for (int c = 359; c <= 390; c++) begin
      if (c == 359)      step(own(PRE, 1'b0, 1'b1, 1'b1));
      else if (c == 362) step(own(AREF, 1'b0, 1'b1, 1'b1));
      else               step(own(NOP, 1'b0, 1'b1, 1'b1));
    end

    phase = "rst_in_user";
    step(mk(1'b1, 1'b0, 4'b0101, 2'b10, 12'h0f0, 1'b1, 1'b1, 1'b1));
    step(mk(1'b1, 1'b0, 4'b0100, 2'b10, 12'h0f1, 1'b1, 1'b1, 1'b1));
    reset_pulse("rst_user");
    phase = "replay1";
    run_init(25);
    reset_pulse("rst_trfc");
    phase = "replay2";
    run_init(39);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
